// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment table, polarity helper and width helper for the 7-segment scan driver
package seg7_pkg;

   // Active-high patterns, bit order g f e d c b a, indexed by hex nibble.
   localparam logic [6:0] SEG_HEX [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [6:0] seg_pol(input logic [6:0] pattern, input logic active_low);
      return active_low ? ~pattern : pattern;
   endfunction

   function automatic int idx_width(input int digits);
      return (digits > 1) ? $clog2(digits) : 1;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - hex nibble to active-high gfedcba segment pattern
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] pattern
);

   assign pattern = SEG_HEX[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment scanner with guard, zero blanking and frame-aligned loads
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int GUARD          = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [4*DIGITS-1:0] value,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic                load,
   input  logic                lz_blank,
   output logic [6:0]          seg,
   output logic                dp,
   output logic [DIGITS-1:0]   an,
   output logic                frame_done
);

   localparam int                IDX_W     = idx_width(DIGITS);
   localparam int                DIV_W     = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0]  GUARD_END = DIV_W'(GUARD);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
   localparam logic [DIGITS-1:0] AN_OFF    = {DIGITS{AN_ACTIVE_LOW}};

   logic [DIV_W-1:0]    div_cnt;
   logic [IDX_W-1:0]    idx;
   logic [4*DIGITS-1:0] shadow_val, active_val;
   logic [DIGITS-1:0]   shadow_dp, active_dp;
   logic                pending;

   logic                slot_end, wrap;
   logic [3:0]          cur_nib;
   logic                cur_dp, cur_blank, upper_nonzero;
   logic [DIGITS-1:0]   cur_sel;
   logic [6:0]          cur_pat;

   assign slot_end = enable && (div_cnt == DIV_LAST);
   assign wrap     = slot_end && (idx == IDX_LAST);

   // Blanking looks at the current digit and everything to its left.
   always_comb begin
      cur_nib       = 4'h0;
      cur_dp        = 1'b0;
      cur_sel       = '0;
      upper_nonzero = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx == IDX_W'(k)) begin
            cur_nib    = active_val[4*k +: 4];
            cur_dp     = active_dp[k];
            cur_sel[k] = 1'b1;
         end
         if ((IDX_W'(k) >= idx) && (active_val[4*k +: 4] != 4'h0)) begin
            upper_nonzero = 1'b1;
         end
      end
      cur_blank = lz_blank && (idx != '0) && !upper_nonzero;
   end

   seg7_decode u_decode (
      .nibble  (cur_nib),
      .pattern (cur_pat)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt    <= '0;
         idx        <= '0;
         shadow_val <= '0;
         shadow_dp  <= '0;
         active_val <= '0;
         active_dp  <= '0;
         pending    <= 1'b0;
         an         <= AN_OFF;
         seg        <= seg_pol(7'h00, SEG_ACTIVE_LOW);
         dp         <= SEG_ACTIVE_LOW;
         frame_done <= 1'b0;
      end else begin
         if (slot_end) begin
            div_cnt <= '0;
            idx     <= wrap ? '0 : idx + 1'b1;
         end else if (enable) begin
            div_cnt <= div_cnt + 1'b1;
         end

         if (load) begin
            shadow_val <= value;
            shadow_dp  <= dp_in;
         end

         // A load landing on the wrap edge bypasses the shadow so it is not delayed a frame.
         if (wrap && load) begin
            active_val <= value;
            active_dp  <= dp_in;
            pending    <= 1'b0;
         end else if (wrap && pending) begin
            active_val <= shadow_val;
            active_dp  <= shadow_dp;
            pending    <= 1'b0;
         end else if (load) begin
            pending    <= 1'b1;
         end

         an         <= (enable && (div_cnt >= GUARD_END)) ? (cur_sel ^ AN_OFF) : AN_OFF;
         seg        <= seg_pol(cur_blank ? 7'h00 : cur_pat, SEG_ACTIVE_LOW);
         dp         <= cur_dp ^ SEG_ACTIVE_LOW;
         frame_done <= wrap;
      end
   end

endmodule
